fsm_out_rle: RTL
================

# fsm_out_rle

Run-length encoder sitting directly downstream of the 5-state Mealy control FSM. It consumes the FSM's 2-bit output symbol stream, one qualified symbol per cycle, and compresses it into (symbol, run length) records. Records are buffered in a small FIFO and drained through a valid/ready handshake to the logging/trace consumer. Dropped records are flagged by a sticky overflow bit.

## Interface
- CNT_W, 6, run-length width; maximum run MAX = 2^CNT_W − 1
- FIFO_DEPTH, 4, record FIFO entries; power of two, ≥ 2
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high
- sym_in  in  2  FSM output symbol
- sym_valid  in  1  sym_in is qualified this cycle
- flush  in  1  close and emit the open run
- rec_valid  out  1  FIFO non-empty; head record presented
- rec_ready  in  1  consumer accepts head record
- rec_sym  out  2  head record symbol
- rec_len  out  CNT_W  head record run length, 1..MAX
- fifo_level  out  $clog2(FIFO_DEPTH+1)  records currently stored
- overflow  out  1  sticky: at least one record dropped

## Operation
- Registers: state {IDLE, RUN}, cur_sym[1:0], cur_len[CNT_W-1:0], FIFO storage, read/write pointers, level, overflow.
- IDLE, sym_valid: cur_sym←sym_in, cur_len←1, go RUN. IDLE, flush alone: no-op.
- RUN, sym_valid, sym_in==cur_sym, cur_len<MAX: cur_len←cur_len+1.
- RUN, sym_valid, sym_in==cur_sym, cur_len==MAX: push (cur_sym, MAX); cur_len←1, stay RUN.
- RUN, sym_valid, sym_in≠cur_sym: push (cur_sym, cur_len); cur_sym←sym_in, cur_len←1.
- RUN, flush, no sym_valid: push (cur_sym, cur_len); go IDLE.
- RUN, flush and sym_valid together: push (cur_sym, cur_len) of the old run only; sym_in opens a new run (len 1), state stays RUN. At most one push per cycle, always.
- Cycles with sym_valid=0 do not break or extend a run.
- Pop when rec_valid && rec_ready. Head outputs are stable while rec_valid && !rec_ready.
- Push while full and no pop the same cycle: record discarded, overflow←1, run bookkeeping proceeds as if pushed. Push while full with a pop the same cycle: accepted, level unchanged.
- Simultaneous push and pop on a non-empty FIFO: level unchanged. Push on an empty FIFO: no bypass; the record appears the next cycle.
- overflow clears only on reset.

## Timing
- Reset (asynchronous, immediate): state IDLE, cur_len 0, FIFO empty, rec_valid 0, rec_sym 0, rec_len 0, fifo_level 0, overflow 0. A run open at reset is lost, not emitted.
- Closing event sampled at edge N → record written at edge N → rec_valid=1 from edge N onward when the FIFO was empty. Latency from the closing cycle to the visible record is 1 cycle.
- Pop at edge M: the next head, or rec_valid=0, is visible after edge M.
- fifo_level and overflow update on the same edge as the push or pop that causes them.
- Combinational path from inputs to outputs: none. All outputs are register- or FIFO-head-driven.

## Test plan
(CNT_W=3, MAX=7, FIFO_DEPTH=4, rec_ready=1 unless stated)
- Symbols 01,01,01,10, then flush → records (01,3), (10,1), each rec_valid 1 cycle after its closing cycle. Then IDLE, fifo_level 0.
- Symbol 11 held for 10 cycles, then flush → (11,7) pushed on the 8th symbol, then (11,3). overflow=0.
- rec_ready=0; symbols 00,01,00,01,00,01, then flush → 6 push attempts. FIFO holds (00,1), (01,1), (00,1), (01,1); fifo_level=4; overflow=1. Then raise rec_ready → exactly those 4 records drain in order.
- 10,10, then a cycle with sym_in=00, sym_valid=1, flush=1 → record (10,2) only; state RUN. Later flush → (00,1).
- Sequence 01, gap (sym_valid=0) ×3, 01, flush → single record (01,2).
- FIFO holding 2 records, run open at len 5: assert reset mid-cycle → rec_valid, fifo_level and overflow are 0 before the next edge. After release, no record appears until new symbols and a closing event.

Source files
------------

// File: rtl/fsm_out_rle.sv
// Run-length encoder for the control FSM output symbol stream.
// Closed runs are queued as (symbol, length) records behind a valid/ready port.
module fsm_out_rle #(
  parameter int CNT_W      = 6,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [1:0]                          sym_in,
  input  logic                                sym_valid,
  input  logic                                flush,
  output logic                                rec_valid,
  input  logic                                rec_ready,
  output logic [1:0]                          rec_sym,
  output logic [CNT_W-1:0]                    rec_len,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]     fifo_level,
  output logic                                overflow
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [CNT_W-1:0] MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);
  localparam logic [LVL_W-1:0] FULL = LVL_W'(FIFO_DEPTH);
  localparam logic [LVL_W-1:0] LV1  = LVL_W'(1);
  localparam logic [PTR_W-1:0] PT1  = PTR_W'(1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [1:0]       sym_q, sym_d;
  logic [CNT_W-1:0] len_q, len_d;

  logic             push;
  logic [1:0]       push_sym;
  logic [CNT_W-1:0] push_len;

  logic [1:0]       sym_mem_q [FIFO_DEPTH];
  logic [CNT_W-1:0] len_mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] rptr_q, wptr_q;
  logic [LVL_W-1:0] lvl_q;
  logic             ovf_q;

  logic             pop;
  logic             full;
  logic             wr;
  logic             drop;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      sym_q   <= '0;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      sym_q   <= sym_d;
      len_q   <= len_d;
    end
  end

  // The record pushed is always the old run; a new symbol reopens at len 1.
  always_comb begin
    state_d  = state_q;
    sym_d    = sym_q;
    len_d    = len_q;
    push     = 1'b0;
    push_sym = sym_q;
    push_len = len_q;
    case (state_q)
      IDLE: begin
        if (sym_valid) begin
          sym_d   = sym_in;
          len_d   = ONE;
          state_d = RUN;
        end
      end
      RUN: begin
        if (sym_valid) begin
          if (flush || (sym_in != sym_q)) begin
            push  = 1'b1;
            sym_d = sym_in;
            len_d = ONE;
          end else if (len_q == MAX) begin
            push  = 1'b1;
            len_d = ONE;
          end else begin
            len_d = len_q + ONE;
          end
        end else if (flush) begin
          push    = 1'b1;
          len_d   = '0;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        len_d   = '0;
      end
    endcase
  end

  assign pop  = (lvl_q != '0) && rec_ready;
  assign full = (lvl_q == FULL);
  assign wr   = push && (!full || pop);
  assign drop = push && full && !pop;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        sym_mem_q[i] <= '0;
        len_mem_q[i] <= '0;
      end
      rptr_q <= '0;
      wptr_q <= '0;
      lvl_q  <= '0;
      ovf_q  <= 1'b0;
    end else begin
      if (wr) begin
        sym_mem_q[wptr_q] <= push_sym;
        len_mem_q[wptr_q] <= push_len;
        wptr_q            <= wptr_q + PT1;
      end
      if (pop) begin
        rptr_q <= rptr_q + PT1;
      end
      if (wr && !pop) begin
        lvl_q <= lvl_q + LV1;
      end else if (!wr && pop) begin
        lvl_q <= lvl_q - LV1;
      end
      if (drop) begin
        ovf_q <= 1'b1;
      end
    end
  end

  // Stale slot contents are masked so an empty FIFO presents zeros.
  assign rec_valid  = (lvl_q != '0);
  assign rec_sym    = rec_valid ? sym_mem_q[rptr_q] : '0;
  assign rec_len    = rec_valid ? len_mem_q[rptr_q] : '0;
  assign fifo_level = lvl_q;
  assign overflow   = ovf_q;

endmodule
